vga_timing_gen: RTL

- Generates 640x480 @ 60 Hz VGA raster timing from the 25 MHz pixel clock.
- Produces pixel coordinates DrawX/DrawY, the active-video flag blank, and the hs/vs sync pulses.
- Sits directly upstream of every sprite/draw stage: they consume DrawX, DrawY and blank and return 4-bit red/green/blue.
- hs/vs go straight to the VGA connector.

---
 rtl/vga_timing_gen.sv | 107 ++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//   640x480 @ 60 Hz VGA raster timing generator, clocked by the 25 MHz pixel
//   clock. A horizontal counter (hc) and a vertical counter (vc) walk the full
//   raster including porches and sync. Every decoded output is registered from
//   the next-state counter values so it lines up with DrawX/DrawY in the same
//   cycle without a comparator-to-pin combinational path.
//
// Ports
//   vga_clk     in   pixel clock, all state on the rising edge
//   reset       in   asynchronous, active-high; forces position (0,0)
//   DrawX       out  [9:0] horizontal count, 0..H_TOTAL-1
//   DrawY       out  [9:0] vertical count,   0..V_TOTAL-1
//   blank       out  1 = active video, 0 = blanking interval
//   hs          out  horizontal sync, active-low
//   vs          out  vertical sync, active-low
//   frame_start out  high while DrawX==0 and DrawY==0
//   line_end    out  high while DrawX==H_TOTAL-1
// -----------------------------------------------------------------------------
module vga_timing_gen #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic       vga_clk,
   input  logic       reset,
   output logic [9:0] DrawX,
   output logic [9:0] DrawY,
   output logic       blank,
   output logic       hs,
   output logic       vs,
   output logic       frame_start,
   output logic       line_end
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   // Counter-width copies of the decode thresholds
   localparam logic [9:0] HC_LAST  = 10'(H_TOTAL - 1);
   localparam logic [9:0] VC_LAST  = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

   logic [9:0] r_hc;
   logic [9:0] r_vc;
   logic       r_blank;
   logic       r_hs;
   logic       r_vs;
   logic       r_frame_start;
   logic       r_line_end;

   logic       w_h_wrap;
   logic [9:0] w_hc_nxt;
   logic [9:0] w_vc_nxt;

   // Next raster position; vc only moves on the cycle hc wraps, so the
   // (last,last) -> (0,0) transition happens in a single edge.
   always_comb begin
      w_h_wrap = (r_hc == HC_LAST);
      w_hc_nxt = w_h_wrap ? 10'd0 : r_hc + 10'd1;
      w_vc_nxt = r_vc;
      if (w_h_wrap) begin
         w_vc_nxt = (r_vc == VC_LAST) ? 10'd0 : r_vc + 10'd1;
      end
   end

   // Decodes use the next-state position so the registered flags describe
   // the same pixel as the registered counters.
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         r_hc          <= 10'd0;
         r_vc          <= 10'd0;
         r_blank       <= 1'b1;
         r_hs          <= 1'b1;
         r_vs          <= 1'b1;
         r_frame_start <= 1'b1;
         r_line_end    <= 1'b0;
      end else begin
         r_hc          <= w_hc_nxt;
         r_vc          <= w_vc_nxt;
         r_blank       <= (w_hc_nxt < H_VIS) && (w_vc_nxt < V_VIS);
         r_hs          <= !((w_hc_nxt >= HS_START) && (w_hc_nxt < HS_END));
         r_vs          <= !((w_vc_nxt >= VS_START) && (w_vc_nxt < VS_END));
         r_frame_start <= (w_hc_nxt == 10'd0) && (w_vc_nxt == 10'd0);
         r_line_end    <= (w_hc_nxt == HC_LAST);
      end
   end

   assign DrawX       = r_hc;
   assign DrawY       = r_vc;
   assign blank       = r_blank;
   assign hs          = r_hs;
   assign vs          = r_vs;
   assign frame_start = r_frame_start;
   assign line_end    = r_line_end;

endmodule
